// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory line port between the icache miss path and the dcache miss/writeback path.
// Optional macro MEM_ARB_RR_EN: round-robin on simultaneous requests; undefined gives the dcache fixed priority.
module mem_port_arbiter #(
  parameter int LINE_WIDTH = 256,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  typedef enum logic {GRANT_I, GRANT_D} grant_t;

  state_t state;
  grant_t last_grant;
  logic   d_req;
  logic   grant_d;
  logic   grant_i;
  logic   resp_ok;

  always_comb begin
    d_req = d_read | d_write;
`ifdef MEM_ARB_RR_EN
    if (d_req && i_read) begin
      grant_d = (last_grant == GRANT_I);
    end else begin
      grant_d = d_req;
    end
`else
    grant_d = d_req;
`endif
    grant_i = i_read && !grant_d;
  end

  // The memory-side strobes, address and data come straight from these registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      last_grant <= GRANT_I;
      mem_read   <= 1'b0;
      mem_write  <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_d) begin
            state     <= SERVE_D;
            mem_addr  <= d_addr;
            mem_wdata <= d_wdata;
            mem_write <= d_write;
            mem_read  <= !d_write;
          end else if (grant_i) begin
            state     <= SERVE_I;
            mem_addr  <= i_addr;
            mem_wdata <= '0;
            mem_write <= 1'b0;
            mem_read  <= 1'b1;
          end
        end
        SERVE_I, SERVE_D: begin
          if (mem_resp) begin
            state      <= IDLE;
            last_grant <= (state == SERVE_D) ? GRANT_D : GRANT_I;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
          end
        end
        default: begin
          state     <= IDLE;
          mem_read  <= 1'b0;
          mem_write <= 1'b0;
        end
      endcase
    end
  end

  // A response coinciding with reset belongs to an abandoned access and is swallowed.
  assign resp_ok = mem_resp && !rst;
  assign i_resp  = (state == SERVE_I) && resp_ok;
  assign d_resp  = (state == SERVE_D) && resp_ok;
  assign i_rdata = i_resp ? mem_rdata : '0;
  assign d_rdata = d_resp ? mem_rdata : '0;

  // last_grant steers only the round-robin build; these keep its bookkeeping checked in both builds.
  a_last_i: assert property (@(posedge clk) disable iff (rst) i_resp |=> (last_grant == GRANT_I));
  a_last_d: assert property (@(posedge clk) disable iff (rst) d_resp |=> (last_grant == GRANT_D));
  a_resp_excl: assert property (@(posedge clk) !(i_resp && d_resp));

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: directed scenarios, then randomized traffic against a
// transaction-level model of the grant/response rules (honours MEM_ARB_RR_EN when defined).
module tb_mem_port_arbiter;

  localparam int LW = 256;
  localparam int AW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          i_read;
  logic [AW-1:0] i_addr;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read;
  logic          d_write;
  logic [AW-1:0] d_addr;
  logic [LW-1:0] d_wdata;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          mem_read;
  logic          mem_write;
  logic [AW-1:0] mem_addr;
  logic [LW-1:0] mem_wdata;
  logic [LW-1:0] mem_rdata;
  logic          mem_resp;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_resp(mem_resp)
  );

  task automatic checkOutput(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drives one cycle's inputs just after the rising edge, then returns mid-cycle for sampling.
  task automatic applyStimulus(input logic r, input logic ir, input logic [AW-1:0] ia,
                               input logic dr, input logic dw, input logic [AW-1:0] da,
                               input logic [LW-1:0] dwd, input logic mr, input logic [LW-1:0] mrd);
    @(posedge clk);
    #1;
    rst = r; i_read = ir; i_addr = ia; d_read = dr; d_write = dw;
    d_addr = da; d_wdata = dwd; mem_resp = mr; mem_rdata = mrd;
    @(negedge clk);
  endtask

  // Grant rule: dcache wins ties, unless round-robin hands the tie to whoever was not served last.
  function automatic bit pickD(input bit ireq, input bit dreq, input bit last_d);
    if (ireq && dreq) begin
`ifdef MEM_ARB_RR_EN
      return !last_d;
`else
      return 1'b1;
`endif
    end
    return dreq;
  endfunction

  function automatic logic [LW-1:0] randLine();
    logic [LW-1:0] v;
    for (int k = 0; k < LW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [AW-1:0] randAddr();
    logic [AW-1:0] a;
    a = $urandom;
    return a & ~32'h1F;
  endfunction

  logic [LW-1:0] pat_a5;
  logic [LW-1:0] pat_w;
  logic [LW-1:0] rd1;
  logic [LW-1:0] rd2;
  logic [AW-1:0] tia;
  logic [AW-1:0] tda;
  bit            last_d;
  bit            first_d;
  int            d_pulses;

  bit            i_pend, d_pend, i_blk, d_blk, dr_drv, dw_drv, mr_drv;
  bit            busy, own_d, lat_wr, exp_ir, exp_dr;
  logic [AW-1:0] ia_r, da_r, lat_a;
  logic [LW-1:0] dwd_r, mrd_r, lat_wd;
  int            wait_n;
  int            op;

  initial begin
    pat_a5 = {32{8'hA5}};
    pat_w  = {8{32'h12345678}};
    rst = 1'b1; i_read = 1'b0; i_addr = '0; d_read = 1'b0; d_write = 1'b0;
    d_addr = '0; d_wdata = '0; mem_resp = 1'b0; mem_rdata = '0;

    // Reset state
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("rst_mem_read", mem_read, 0);
    checkOutput("rst_mem_write", mem_write, 0);
    checkOutput("rst_mem_addr", mem_addr, 0);
    checkOutput("rst_mem_wdata", mem_wdata, 0);
    checkOutput("rst_i_resp", i_resp, 0);
    checkOutput("rst_d_resp", d_resp, 0);
    last_d = 1'b0;

    // Icache read, memory answers on the third service cycle
    applyStimulus(0, 1, 32'h1040, 0, 0, 0, 0, 0, 0);
    checkOutput("i_idle_read", mem_read, 0);
    applyStimulus(0, 1, 32'h1040, 0, 0, 0, 0, 0, 0);
    checkOutput("i_mem_read", mem_read, 1);
    checkOutput("i_mem_addr", mem_addr, 32'h1040);
    checkOutput("i_mem_write", mem_write, 0);
    applyStimulus(0, 1, 32'h1040, 0, 0, 0, 0, 0, 0);
    checkOutput("i_wait_resp", i_resp, 0);
    applyStimulus(0, 1, 32'h1040, 0, 0, 0, 0, 1, pat_a5);
    checkOutput("i_resp", i_resp, 1);
    checkOutput("i_rdata", i_rdata, pat_a5);
    checkOutput("i_no_d_resp", d_resp, 0);
    checkOutput("i_d_rdata_zero", d_rdata, 0);
    applyStimulus(0, 0, 32'h1040, 0, 0, 0, 0, 0, 0);
    checkOutput("i_after_resp", i_resp, 0);
    checkOutput("i_after_read", mem_read, 0);

    // Dcache writeback, address changed mid-service
    d_pulses = 0;
    applyStimulus(0, 0, 0, 0, 1, 32'h2000, pat_w, 0, 0);
    d_pulses += int'(d_resp);
    checkOutput("d_idle_write", mem_write, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h2000, pat_w, 0, 0);
    d_pulses += int'(d_resp);
    checkOutput("d_mem_write", mem_write, 1);
    checkOutput("d_mem_read", mem_read, 0);
    checkOutput("d_mem_addr", mem_addr, 32'h2000);
    checkOutput("d_mem_wdata", mem_wdata, pat_w);
    applyStimulus(0, 0, 0, 0, 1, 32'h3000, ~pat_w, 0, 0);
    d_pulses += int'(d_resp);
    checkOutput("d_addr_held", mem_addr, 32'h2000);
    checkOutput("d_wdata_held", mem_wdata, pat_w);
    checkOutput("d_read_low", mem_read, 0);
    applyStimulus(0, 0, 0, 0, 1, 32'h3000, ~pat_w, 1, pat_a5);
    d_pulses += int'(d_resp);
    checkOutput("d_resp", d_resp, 1);
    checkOutput("d_no_i_resp", i_resp, 0);
    checkOutput("d_addr_at_resp", mem_addr, 32'h2000);
    applyStimulus(0, 0, 0, 0, 0, 32'h3000, 0, 0, 0);
    d_pulses += int'(d_resp);
    checkOutput("d_after_write", mem_write, 0);
    checkOutput("d_resp_pulses", d_pulses, 1);
    last_d = 1'b1;

    // Two simultaneous request pairs
    for (int k = 0; k < 2; k++) begin
      tia = 32'h4000 + 32'h100 * k;
      tda = 32'h5000 + 32'h100 * k;
      rd1 = randLine();
      rd2 = randLine();
      first_d = pickD(1'b1, 1'b1, last_d);
      applyStimulus(0, 1, tia, 1, 0, tda, 0, 0, 0);
      checkOutput("tie_idle_read", mem_read, 0);
      applyStimulus(0, 1, tia, 1, 0, tda, 0, 1, rd1);
      checkOutput("tie_first_addr", mem_addr, first_d ? tda : tia);
      checkOutput("tie_first_d_resp", d_resp, first_d);
      checkOutput("tie_first_i_resp", i_resp, !first_d);
      checkOutput("tie_first_rdata", first_d ? d_rdata : i_rdata, rd1);
      applyStimulus(0, first_d, tia, !first_d, 0, tda, 0, 0, 0);
      checkOutput("tie_gap_read", mem_read, 0);
      applyStimulus(0, first_d, tia, !first_d, 0, tda, 0, 1, rd2);
      checkOutput("tie_second_read", mem_read, 1);
      checkOutput("tie_second_addr", mem_addr, first_d ? tia : tda);
      checkOutput("tie_second_i_resp", i_resp, first_d);
      checkOutput("tie_second_d_resp", d_resp, !first_d);
      checkOutput("tie_second_rdata", first_d ? i_rdata : d_rdata, rd2);
      applyStimulus(0, 0, tia, 0, 0, tda, 0, 0, 0);
      checkOutput("tie_done_read", mem_read, 0);
      last_d = !first_d;
    end

    // Reset during icache service, stale memory response afterwards
    applyStimulus(0, 1, 32'h6000, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 1, 32'h6000, 0, 0, 0, 0, 0, 0);
    checkOutput("rstmid_serving", mem_read, 1);
    applyStimulus(1, 1, 32'h6000, 0, 0, 0, 0, 0, 0);
    checkOutput("rstmid_no_resp0", i_resp, 0);
    applyStimulus(0, 0, 32'h6000, 0, 0, 0, 0, 0, 0);
    checkOutput("rstmid_read_low", mem_read, 0);
    checkOutput("rstmid_no_resp1", i_resp, 0);
    applyStimulus(0, 0, 32'h6000, 0, 0, 0, 0, 1, pat_a5);
    checkOutput("rstmid_stale_i", i_resp, 0);
    checkOutput("rstmid_stale_d", d_resp, 0);
    checkOutput("rstmid_stale_read", mem_read, 0);
    last_d = 1'b0;

    // Spurious response while idle
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 1, pat_a5);
    checkOutput("spur_i_resp", i_resp, 0);
    checkOutput("spur_d_resp", d_resp, 0);
    checkOutput("spur_i_rdata", i_rdata, 0);
    checkOutput("spur_d_rdata", d_rdata, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("spur_mem_read", mem_read, 0);
    checkOutput("spur_mem_write", mem_write, 0);
    checkOutput("spur_mem_addr", mem_addr, 0);

    // Randomized traffic against the transaction-level model
    i_pend = 0; d_pend = 0; i_blk = 0; d_blk = 0; dr_drv = 0; dw_drv = 0;
    busy = 0; own_d = 0; lat_wr = 0; wait_n = 0;
    ia_r = '0; da_r = '0; dwd_r = '0; lat_a = '0; lat_wd = '0;
    for (int c = 0; c < 3000; c++) begin
      if (!i_pend && !i_blk && $urandom_range(0, 2) == 0) begin
        i_pend = 1;
        ia_r = randAddr();
      end
      if (!d_pend && !d_blk && $urandom_range(0, 2) == 0) begin
        op = $urandom_range(0, 4);
        d_pend = 1;
        da_r = randAddr();
        dwd_r = randLine();
        dr_drv = (op <= 1) || (op == 4);
        dw_drv = (op == 2) || (op == 3) || (op == 4);
      end
      i_blk = 0;
      d_blk = 0;
      if (busy && !own_d) ia_r = randAddr();
      if (busy && own_d) begin
        da_r = randAddr();
        dwd_r = randLine();
      end
      mr_drv = busy ? (wait_n == 0) : ($urandom_range(0, 7) == 0);
      mrd_r = randLine();
      applyStimulus(0, i_pend, ia_r, d_pend && dr_drv, d_pend && dw_drv, da_r, dwd_r, mr_drv, mrd_r);

      exp_ir = busy && !own_d && mr_drv;
      exp_dr = busy && own_d && mr_drv;
      checkOutput("rnd_mem_read", mem_read, busy && !lat_wr);
      checkOutput("rnd_mem_write", mem_write, busy && lat_wr);
      if (busy) checkOutput("rnd_mem_addr", mem_addr, lat_a);
      if (busy && lat_wr) checkOutput("rnd_mem_wdata", mem_wdata, lat_wd);
      checkOutput("rnd_i_resp", i_resp, exp_ir);
      checkOutput("rnd_d_resp", d_resp, exp_dr);
      checkOutput("rnd_i_rdata", i_rdata, exp_ir ? mrd_r : '0);
      checkOutput("rnd_d_rdata", d_rdata, exp_dr ? mrd_r : '0);

      if (busy) begin
        if (mr_drv) begin
          busy = 0;
          last_d = own_d;
          if (own_d) begin
            d_pend = 0;
            d_blk = 1;
          end else begin
            i_pend = 0;
            i_blk = 1;
          end
        end else begin
          wait_n--;
        end
      end else if (i_pend || d_pend) begin
        own_d = pickD(i_pend, d_pend, last_d);
        busy = 1;
        lat_a = own_d ? da_r : ia_r;
        lat_wr = own_d && dw_drv;
        lat_wd = dwd_r;
        wait_n = $urandom_range(0, 3);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
